dice_roller: RTL and testbench

Dice source for the craps game controller. It turns the raw roll button into a clean roll strobe and spins two 1..6 dice counters while the button is held. On release it latches the dice and their 2..12 sum. Its `rb_out`/`sum` pair is exactly what the game FSM consumes: `sum` is stable and valid whenever `rb_out` is low after the first roll.

---
 rtl/dice_roller.sv | 156 +++++++++++++++
 tb/tb_dice_roller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Purpose: debounced roll button, odometer-style 1..6 dice counters, and latched 2..12 sum.
// Latency: rb -> rb_out high in 3 edges (plus DB_CYCLES with DICE_DEBOUNCE_EN); release -> sum/sum_valid in 3 edges.
// Backpressure: none; the consumer samples sum whenever sum_valid is high. DICE_DEBOUNCE_EN enables the debounce filter.
module dice_roller #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rb,
  output logic       rb_out,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       sum_valid,
  output logic [7:0] roll_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    HOLD    = 2'd2
  } state_t;

  logic       rb_meta_q;
  logic       rb_s_q;
  logic       rb_db;

  state_t     state_q;
  logic       rb_out_q;
  logic       sum_valid_q;
  logic [2:0] die1_q;
  logic [2:0] die2_q;
  logic [3:0] sum_q;
  logic [7:0] roll_count_q;

  logic [2:0] die1_d;
  logic [2:0] die2_d;
  logic [3:0] sum_d;
  logic       die1_wrap;

  // Two-flop synchronizer bringing the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_meta_q <= 1'b0;
      rb_s_q    <= 1'b0;
    end else begin
      rb_meta_q <= rb;
      rb_s_q    <= rb_meta_q;
    end
  end

`ifdef DICE_DEBOUNCE_EN
  localparam logic [7:0] DbLimit = 8'(DB_CYCLES);

  logic [7:0] db_cnt_q;
  logic [7:0] db_cnt_d;
  logic       rb_db_q;
  logic       rb_db_d;

  // Count consecutive disagreeing cycles; adopt the new level once the count hits the limit
  always_comb begin
    db_cnt_d = 8'd0;
    rb_db_d  = rb_db_q;
    if (rb_s_q != rb_db_q) begin
      if ((db_cnt_q + 8'd1) == DbLimit) begin
        rb_db_d  = rb_s_q;
        db_cnt_d = 8'd0;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  // Debounce counter and filtered level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q <= 8'd0;
      rb_db_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      rb_db_q  <= rb_db_d;
    end
  end

  assign rb_db = rb_db_q;
`else
  // Without the filter the synchronized level is used directly; DB_CYCLES has no effect
  logic unused_db;
  assign unused_db = (DB_CYCLES == 0);
  assign rb_db     = rb_s_q;
`endif

  // Odometer stepping: die2 moves only when die1 wraps 6 -> 1
  assign die1_wrap = (die1_q == 3'd6);
  assign die1_d    = die1_wrap ? 3'd1 : (die1_q + 3'd1);
  assign die2_d    = (die2_q == 3'd6) ? 3'd1 : (die2_q + 3'd1);
  assign sum_d     = {1'b0, die1_q} + {1'b0, die2_q};

  // Roll FSM with registered decodes, dice counters, sum latch and roll counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rb_out_q     <= 1'b0;
      sum_valid_q  <= 1'b0;
      die1_q       <= 3'd1;
      die2_q       <= 3'd1;
      sum_q        <= 4'd0;
      roll_count_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rb_db) begin
            state_q     <= ROLLING;
            rb_out_q    <= 1'b1;
            sum_valid_q <= 1'b0;
          end
        end
        ROLLING: begin
          if (rb_db) begin
            die1_q <= die1_d;
            if (die1_wrap) begin
              die2_q <= die2_d;
            end
          end else begin
            // Latch the pre-edge dice; counters hold on the release edge
            state_q      <= HOLD;
            rb_out_q     <= 1'b0;
            sum_valid_q  <= 1'b1;
            sum_q        <= sum_d;
            roll_count_q <= roll_count_q + 8'd1;
          end
        end
        HOLD: begin
          if (rb_db) begin
            state_q     <= ROLLING;
            rb_out_q    <= 1'b1;
            sum_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rb_out_q    <= 1'b0;
          sum_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rb_out     = rb_out_q;
  assign sum_valid  = sum_valid_q;
  assign die1       = die1_q;
  assign die2       = die2_q;
  assign sum        = sum_q;
  assign roll_count = roll_count_q;

endmodule

// File: tb/tb_dice_roller.sv
// Purpose: self-checking bench for dice_roller using a dice model and a result scoreboard.
// Latency: expected rolls are queued at press time and compared when sum_valid rises.
// Backpressure: none; every wait on the DUT is bounded and a timeout counts as an error.
module tb_dice_roller;

  logic       clk;
  logic       reset;
  logic       rb;
  logic       rb_out;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       sum_valid;
  logic [7:0] roll_count;

  int n_checks;
  int n_errors;

  typedef struct {
    int d1;
    int d2;
    int s;
    int cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference dice state
  int m_d1;
  int m_d2;
  int m_cnt;
  int m_sum;

  dice_roller #(.DB_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rb         (rb),
    .rb_out     (rb_out),
    .die1       (die1),
    .die2       (die2),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .roll_count (roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1  = 1;
    m_d2  = 1;
    m_cnt = 0;
    m_sum = 0;
  endtask

  task automatic model_advance();
    if (m_d1 == 6) begin
      m_d1 = 1;
      m_d2 = (m_d2 == 6) ? 1 : m_d2 + 1;
    end else begin
      m_d1 = m_d1 + 1;
    end
  endtask

  // Press for n+1 cycles (n counter advances), release, and score the latched result
  task automatic roll(input int n, input bit reroll_chk);
    exp_t e;
    exp_t got_e;
    int   old_sum;
    int   prev_rb;
    bit   seen;
    bit   got;
    old_sum = m_sum;
    for (int k = 0; k < n; k++) model_advance();
    m_cnt = (m_cnt + 1) % 256;
    m_sum = m_d1 + m_d2;
    e.d1  = m_d1;
    e.d2  = m_d2;
    e.s   = m_sum;
    e.cnt = m_cnt;
    sb_q.push_back(e);

    rb = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (reroll_chk && i == 2) begin
        chk("reroll_rb_out", int'(rb_out), 1);
        chk("reroll_valid_low", int'(sum_valid), 0);
        chk("reroll_sum_held", int'(sum), old_sum);
      end
    end
    rb      = 1'b0;
    prev_rb = int'(rb_out);
    seen    = rb_out;
    got     = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk);
      #1;
      if (seen && sum_valid) begin
        got = 1'b1;
        chk("rb_out_low_with_valid", int'(rb_out), 0);
        chk("rb_out_high_before_valid", prev_rb, 1);
      end
      if (rb_out) seen = 1'b1;
      prev_rb = int'(rb_out);
    end
    if (!got) begin
      chk("sum_valid_timeout", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      got_e = sb_q.pop_front();
      chk("die1", int'(die1), got_e.d1);
      chk("die2", int'(die2), got_e.d2);
      chk("sum", int'(sum), got_e.s);
      chk("roll_count", int'(roll_count), got_e.cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_die1"}, int'(die1), 1);
    chk({tag, "_die2"}, int'(die2), 1);
    chk({tag, "_sum"}, int'(sum), 0);
    chk({tag, "_sum_valid"}, int'(sum_valid), 0);
    chk({tag, "_rb_out"}, int'(rb_out), 0);
    chk({tag, "_roll_count"}, int'(roll_count), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    rb       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifdef DICE_DEBOUNCE_EN
    begin
      bit seen_glitch;
      int lat;
      bit got;
      // Short glitch must be filtered
      rb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rb = 1'b0;
      seen_glitch = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk);
        #1;
        if (rb_out) seen_glitch = 1'b1;
      end
      chk("db_glitch_rb_out", int'(seen_glitch), 0);

      // Ten-cycle press: rb_out rises 2 + 4 + 1 edges after rb
      rb  = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (rb_out && lat == 0) lat = i;
        if (i == 10) rb = 1'b0;
      end
      chk("db_press_latency", lat, 7);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        if (sum_valid) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      chk("db_sum_valid", int'(got), 1);
      chk("db_roll_count", int'(roll_count), 1);
      chk("db_die1", int'(die1), 4);
      chk("db_die2", int'(die2), 2);
      chk("db_sum", int'(sum), 6);
    end
`else
    // Odometer progression and wrap
    roll(7, 1'b0);
    roll(28, 1'b0);
    roll(1, 1'b0);
    // Re-roll from HOLD: sum_valid drops with rb_out, old sum held
    roll(4, 1'b1);
    roll(0, 1'b1 ^ 1'b1);

    // Reset in the middle of a roll discards it
    rb = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midroll_rb_out", int'(rb_out), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midroll");
    rb = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_no_latch", int'(sum_valid), 0);

    // 256 completed rolls wrap roll_count back to zero
    for (int r = 0; r < 256; r++) begin
      roll(int'($urandom_range(0, 3)), 1'b0);
    end
    chk("roll_count_wrap", int'(roll_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
